// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: radix-4 Booth multiplier retiring one digit per clock; ports clk/rst, in_valid/in_ready/is_signed/multiplicand/multiplier in, out_valid/out_ready/product out, busy
module booth_seq_multiplier #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIGITS = DATA_WIDTH/2 + 1,
  parameter int PROD_WIDTH = 2*DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PROD_WIDTH-1:0] product,
  output logic                  busy
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [PROD_WIDTH-1:0] a, acc, pp;
  logic [DATA_WIDTH+2:0] b;
  logic [CW-1:0] cnt;
  logic [2:0] code;
  assign code = b[2:0];
  assign in_ready = !rst && state == IDLE;
  always_comb
    pp = (code == 3'b001 || code == 3'b010) ? a :
         code == 3'b011 ? a << 1 :
         code == 3'b100 ? -(a << 1) :
         (code == 3'b101 || code == 3'b110) ? -a : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      product <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      a <= '0;
      b <= '0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          a <= {{(PROD_WIDTH-DATA_WIDTH){is_signed & multiplicand[DATA_WIDTH-1]}}, multiplicand};
          b <= {{2{is_signed & multiplier[DATA_WIDTH-1]}}, multiplier, 1'b0};
          acc <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= BUSY;
        end
        BUSY: begin
          acc <= acc + pp;
          a <= a << 2;
          b <= b >> 2;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NUM_DIGITS - 1)) begin
            product <= acc + pp;
            busy <= 1'b0;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: self-checking bench for booth_seq_multiplier at W=8 and W=32
module tb_booth_seq_multiplier;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic v8 = 1'b0, s8 = 1'b0, or8 = 1'b0, rdy8, ov8, busy8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic v32 = 1'b0, s32 = 1'b0, or32 = 1'b0, rdy32, ov32, busy32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] p32;
  int n_checks = 0, n_fail = 0;
  logic [7:0] ta [6] = '{8'hFF, 8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h00};
  logic [7:0] tbv [6] = '{8'hFF, 8'h80, 8'h01, 8'h01, 8'h80, 8'h5A};
  logic ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] te [6] = '{16'hFE01, 16'h4000, 16'hFFFF, 16'h00FF, 16'hC080, 16'h0000};

  booth_seq_multiplier #(.DATA_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .is_signed(s8),
    .multiplicand(a8), .multiplier(b8), .out_valid(ov8), .out_ready(or8),
    .product(p8), .busy(busy8));

  booth_seq_multiplier #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .is_signed(s32),
    .multiplicand(a32), .multiplier(b32), .out_valid(ov32), .out_ready(or32),
    .product(p32), .busy(busy32));

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s, input int w);
    logic [63:0] ea, eb, mask;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (s && a[w-1]) ea = ea | (~64'd0 << w);
    if (s && b[w-1]) eb = eb | (~64'd0 << w);
    mask = (w == 32) ? ~64'd0 : (64'd1 << (2*w)) - 64'd1;
    return (ea * eb) & mask;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat, output int bc);
    int w = 0;
    while (!rdy8 && w < 50) begin step(); w++; end
    n_checks++;
    if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL ready8_wait: in_ready=%b want 1", rdy8); end
    a8 = a; b8 = b; s8 = s; v8 = 1'b1;
    step();
    v8 = 1'b0;
    lat = 0; bc = 0;
    while (!ov8 && lat < 50) begin if (busy8) bc++; step(); lat++; end
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat, output int bc);
    int w = 0;
    while (!rdy32 && w < 50) begin step(); w++; end
    n_checks++;
    if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL ready32_wait: in_ready=%b want 1", rdy32); end
    a32 = a; b32 = b; s32 = s; v32 = 1'b1;
    step();
    v32 = 1'b0;
    lat = 0; bc = 0;
    while (!ov32 && lat < 80) begin if (busy32) bc++; step(); lat++; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(); step();
    n_checks++; if (p8 !== 16'h0) begin n_fail++; $display("FAIL reset_product8: got %h want 0000", p8); end
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8: got %b want 0", ov8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    n_checks++; if (rdy8 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready8: got %b want 0", rdy8); end
    n_checks++; if (p32 !== 64'h0) begin n_fail++; $display("FAIL reset_product32: got %h want 0", p32); end
    n_checks++; if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready32: got %b want 0", rdy32); end
    rst = 1'b0;
    #1;
    n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready8: got %b want 1", rdy8); end
    n_checks++; if (rdy32 !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready32: got %b want 1", rdy32); end
  endtask

  task automatic test_directed;
    int lat, bc;
    or8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive8(ta[i], tbv[i], ts[i], lat, bc);
      n_checks++; if (p8 !== te[i]) begin n_fail++; $display("FAIL directed_product[%0d]: got %h want %h", i, p8, te[i]); end
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 5", i, lat); end
      n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL directed_busy_cycles[%0d]: got %0d want 5", i, bc); end
      step();
      n_checks++; if ({ov8, p8} !== {1'b0, te[i]}) begin n_fail++; $display("FAIL directed_after_take[%0d]: out_valid=%b product=%h want 0 %h", i, ov8, p8, te[i]); end
    end
  endtask

  task automatic test_backpressure;
    int lat, bc;
    or8 = 1'b0;
    drive8(8'h12, 8'h34, 1'b0, lat, bc);
    n_checks++; if (p8 !== 16'h03A8) begin n_fail++; $display("FAIL bp_product: got %h want 03a8", p8); end
    a8 = 8'h05; b8 = 8'h07; s8 = 1'b0; v8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({ov8, p8, rdy8, busy8} !== {1'b1, 16'h03A8, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b product=%h in_ready=%b busy=%b want 1 03a8 0 0", i, ov8, p8, rdy8, busy8);
      end
    end
    or8 = 1'b1;
    step();
    n_checks++; if ({ov8, rdy8} !== 2'b01) begin n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", ov8, rdy8); end
    step();
    v8 = 1'b0;
    n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL bp_accept_after: busy=%b want 1", busy8); end
    lat = 0;
    while (!ov8 && lat < 50) begin step(); lat++; end
    n_checks++; if (p8 !== 16'h0023 || lat !== 5) begin n_fail++; $display("FAIL bp_second_op: product=%h latency=%0d want 0023 5", p8, lat); end
    step();
  endtask

  task automatic test_reset_mid;
    or8 = 1'b1;
    a8 = 8'h77; b8 = 8'h66; s8 = 1'b0; v8 = 1'b1;
    step();
    v8 = 1'b0;
    step(); step();
    n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy8); end
    rst = 1'b1;
    step();
    n_checks++;
    if ({ov8, p8, busy8, rdy8} !== {1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_state: out_valid=%b product=%h busy=%b in_ready=%b want 0 0000 0 0", ov8, p8, busy8, rdy8);
    end
    rst = 1'b0;
    #1;
    n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: in_ready=%b want 1", rdy8); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if ({ov8, busy8} !== 2'b00) begin n_fail++; $display("FAIL midrst_spurious[%0d]: out_valid=%b busy=%b want 0 0", i, ov8, busy8); end
    end
  endtask

  task automatic test_churn;
    int lat;
    logic [63:0] e;
    e = ref_mul(32'h9C, 32'hB5, 1'b1, 8);
    or8 = 1'b1;
    a8 = 8'h9C; b8 = 8'hB5; s8 = 1'b1; v8 = 1'b1;
    step();
    lat = 0;
    while (!ov8 && lat < 50) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); v8 = 1'($urandom);
      step();
      lat++;
    end
    v8 = 1'b0;
    n_checks++; if (p8 !== e[15:0] || lat !== 5) begin n_fail++; $display("FAIL churn: product=%h latency=%0d want %h 5", p8, lat, e[15:0]); end
    step();
  endtask

  task automatic test_random8(input int n);
    int lat, bc, stall;
    logic [7:0] a, b;
    logic s;
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      e = ref_mul({24'b0, a}, {24'b0, b}, s, 8);
      or8 = 1'b0;
      drive8(a, b, s, lat, bc);
      n_checks++;
      if (p8 !== e[15:0] || lat !== 5 || bc !== 5) begin
        n_fail++;
        $display("FAIL rand8[%0d] %h*%h s=%b: product=%h latency=%0d busy=%0d want %h 5 5", i, a, b, s, p8, lat, bc, e[15:0]);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        step();
        n_checks++; if ({ov8, p8} !== {1'b1, e[15:0]}) begin n_fail++; $display("FAIL rand8_stall[%0d]: out_valid=%b product=%h want 1 %h", i, ov8, p8, e[15:0]); end
      end
      or8 = 1'b1;
      step();
    end
    or8 = 1'b0;
  endtask

  task automatic test_random32(input int n);
    int lat, bc, stall;
    logic [31:0] a, b;
    logic s;
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      a = (i == 0) ? 32'h8000_0000 : (i == 1) ? 32'hFFFF_FFFF : $urandom;
      b = (i == 0) ? 32'h8000_0000 : (i == 1) ? 32'hFFFF_FFFF : $urandom;
      s = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom);
      e = ref_mul(a, b, s, 32);
      or32 = 1'b0;
      drive32(a, b, s, lat, bc);
      n_checks++;
      if (p32 !== e || lat !== 17 || bc !== 17) begin
        n_fail++;
        $display("FAIL rand32[%0d] %h*%h s=%b: product=%h latency=%0d busy=%0d want %h 17 17", i, a, b, s, p32, lat, bc, e);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        step();
        n_checks++; if ({ov32, p32} !== {1'b1, e}) begin n_fail++; $display("FAIL rand32_stall[%0d]: out_valid=%b product=%h want 1 %h", i, ov32, p32, e); end
      end
      or32 = 1'b1;
      step();
    end
    or32 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_churn();
    test_random8(300);
    test_random32(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
